aes_sched: RTL
==============

# aes_sched

Two-requester scheduler for the shared `aes` round datapath: AddRoundKey, ShiftRows, MixColumns. It arbitrates round-robin between two clients and issues one-cycle `valid` pulses to the core. It collects the three staged results, qualified by the core's `count` output, and returns them as one response with a valid/ready handshake. It also guards each stage with a timeout so a hung core cannot deadlock the clients.

## Interface
- `TIMEOUT`, 16: maximum cycles spent in any WAIT state before aborting; range 2..255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  client 0 has an operation pending.
- `req0_ready`  out  1  client 0 operation accepted this cycle.
- `req0_data`  in  128  client 0 state matrix (plaintext).
- `req0_key`  in  128  client 0 round key.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_key`: same as client 0, for client 1.
- `aes_valid`  out  1  one-cycle start pulse to the core.
- `aes_matrix1`  out  128  state to the core.
- `aes_matrix2`  out  128  key to the core.
- `aes_count`  in  2  core stage indicator.
- `aes_matrix3`  in  128  core stage result.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_err`  out  1  operation aborted by timeout.
- `rsp_ark`  out  128  AddRoundKey result.
- `rsp_sr`  out  128  ShiftRows result.
- `rsp_mc`  out  128  MixColumns result.

## Operation
- FSM states: IDLE, ISSUE, WAIT1, WAIT2, WAIT3, RESP.
- Arbitration in IDLE:
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant the requester that is not `last_grant`.
  - `reqN_ready` = (state==IDLE) & grant==N; this is combinational, and at most one is high.
  - On handshake, latch data, key and id, clear timeout counter and `rsp_err`, zero the three result registers, and go to ISSUE.
- ISSUE:
  - `aes_valid`=1, with `aes_matrix1`/`aes_matrix2` = latched data/key.
  - Always lasts exactly one cycle, then go to WAIT1.
  - Outside ISSUE, `aes_valid`=0 and both matrices drive 0.
- WAITn, n=1..3:
  - `aes_count`==n: capture `aes_matrix3` into the ark/sr/mc register, clear the timer, advance to WAIT(n+1); WAIT3 advances to RESP.
  - Any other `aes_count` value is ignored, including a stale 3 still held from the previous operation; the timer increments.
  - Timer reaching `TIMEOUT`-1 without a match: set `rsp_err`, go to RESP. Uncaptured result registers stay 0.
- RESP:
  - `rsp_valid`=1; all `rsp_*` outputs are held stable until `rsp_ready`.
  - On handshake: `last_grant` <= `rsp_id`, go to IDLE.
  - No new request is accepted until the response handshake completes; the block holds at most one operation in flight.
- Timer: 8-bit saturating counter. Never wraps.

## Timing
- Reset values:
  - State IDLE.
  - `last_grant`=1, so client 0 wins the first tie.
  - `aes_valid`=0, `aes_matrix1`/`aes_matrix2`=0.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_id`=0, all result registers 0.
  - `req0_ready`/`req1_ready` follow combinationally from state: both 0 in reset, and the winner's ready is high in the first IDLE cycle.
- Handshake at edge E0:
  - `aes_valid` is high in cycle E0..E1.
  - WAIT1 begins at E1.
  - Each stage capture costs the core's stage latency plus zero scheduler cycles: the capture edge is the edge that samples `aes_count`==n.
  - `rsp_valid` rises in the cycle after the edge that samples `aes_count`==3.
- Minimum scheduler overhead per operation: 1 cycle ISSUE, 1 cycle RESP (with `rsp_ready` held high), 1 cycle IDLE. This gives the minimum cycle count from handshake to next handshake.
- Async reset at any point, including mid-WAIT or during RESP: immediately returns to the reset values. The in-flight operation is dropped without a response.
- Simultaneous request arrival in RESP is not lost: the `reqN_valid` inputs are simply re-sampled in IDLE.

## Test plan
- Single op: `req0_valid` with data 00112233_44556677_8899aabb_ccddeeff and key 54686973_49734153_65637265_744B6579, `rsp_ready`=1. Required: one `aes_valid` pulse, then `rsp_valid` with `rsp_id`=0, `rsp_err`=0, and ark/sr/mc equal to the core golden values.
- Tie after reset: both valid in the same cycle. Required: client 0 granted first, then client 1, then client 0 again with both held; grants strictly alternate over 8 ops.
- Backpressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` rises. Required: outputs constant, `req0_ready`/`req1_ready` stay 0, accepted only on the ready edge.
- Stale count: core holds `aes_count`=3 from the prior op entering WAIT1. Required: no capture until `aes_count`=1.
- Timeout: core stub never asserts count 2. Required: `TIMEOUT` (16) cycles in WAIT2, then `rsp_err`=1, `rsp_ark` valid, `rsp_sr`=`rsp_mc`=0.
- Reset mid-WAIT2: `rst` low for one cycle. Required: `aes_valid`=0, `rsp_valid`=0, state IDLE; the next tie grants client 0.

Source files
------------

// File: rtl/aes_sched.sv
// aes_sched: two-client round-robin scheduler for the shared AES round
// datapath. Issues one start pulse per operation, collects the AddRoundKey,
// ShiftRows and MixColumns stage results qualified by aes_count, and returns
// them as one response with a per-stage timeout guard.
module aes_sched #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,

  output logic         aes_valid,
  output logic [127:0] aes_matrix1,
  output logic [127:0] aes_matrix2,
  input  logic [1:0]   aes_count,
  input  logic [127:0] aes_matrix3,

  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [127:0] rsp_ark,
  output logic [127:0] rsp_sr,
  output logic [127:0] rsp_mc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT1,
    S_WAIT2,
    S_WAIT3,
    S_RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_last_grant;
  logic         r_id;
  logic         r_err;
  logic [127:0] r_data;
  logic [127:0] r_key;
  logic [127:0] r_ark;
  logic [127:0] r_sr;
  logic [127:0] r_mc;
  logic [7:0]   r_timer;

  logic         w_grant;
  logic         w_idle;
  logic         w_accept;
  logic         w_waiting;
  logic         w_match;
  logic         w_timeout;
  logic         w_rsp_done;

  // Arbitration and request handshake; ready is held low while reset is asserted
  always_comb begin
    w_grant    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    w_idle     = (r_state == S_IDLE) & rst;
    req0_ready = w_idle & req0_valid & ~w_grant;
    req1_ready = w_idle & req1_valid &  w_grant;
    w_accept   = req0_ready | req1_ready;
  end

  // Stage qualification: only the count value belonging to the current WAIT state captures
  always_comb begin
    w_waiting  = (r_state == S_WAIT1) | (r_state == S_WAIT2) | (r_state == S_WAIT3);
    w_match    = ((r_state == S_WAIT1) & (aes_count == 2'd1)) |
                 ((r_state == S_WAIT2) & (aes_count == 2'd2)) |
                 ((r_state == S_WAIT3) & (aes_count == 2'd3));
    w_timeout  = w_waiting & ~w_match & (r_timer == TMO_LAST);
    w_rsp_done = (r_state == S_RESP) & rsp_ready;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT1;
      S_WAIT1: begin
        if (w_match)        w_state_nxt = S_WAIT2;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_WAIT2: begin
        if (w_match)        w_state_nxt = S_WAIT3;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_WAIT3: begin
        if (w_match | w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP:  if (w_rsp_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Latch the granted client's operands and id on the request handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_key  <= '0;
      r_id   <= 1'b0;
    end else if (w_accept) begin
      r_data <= w_grant ? req1_data : req0_data;
      r_key  <= w_grant ? req1_key  : req0_key;
      r_id   <= w_grant;
    end
  end

  // Per-stage timer: cleared on accept and on every capture, saturates instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_accept) begin
      r_timer <= '0;
    end else if (w_waiting) begin
      if (w_match)                r_timer <= '0;
      else if (r_timer != 8'hFF)  r_timer <= r_timer + 8'd1;
    end
  end

  // Abort flag: cleared on accept, set when a WAIT stage runs out of time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_err <= 1'b0;
    else if (w_accept)  r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  // Stage result capture; registers of stages never reached stay zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ark <= '0;
      r_sr  <= '0;
      r_mc  <= '0;
    end else if (w_accept) begin
      r_ark <= '0;
      r_sr  <= '0;
      r_mc  <= '0;
    end else if (w_match) begin
      if (r_state == S_WAIT1) r_ark <= aes_matrix3;
      if (r_state == S_WAIT2) r_sr  <= aes_matrix3;
      if (r_state == S_WAIT3) r_mc  <= aes_matrix3;
    end
  end

  // Round-robin history, updated only when the response is consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_last_grant <= 1'b1;
    else if (w_rsp_done) r_last_grant <= r_id;
  end

  // Core issue and response outputs
  always_comb begin
    aes_valid   = (r_state == S_ISSUE);
    aes_matrix1 = aes_valid ? r_data : '0;
    aes_matrix2 = aes_valid ? r_key  : '0;
    rsp_valid   = (r_state == S_RESP);
    rsp_id      = r_id;
    rsp_err     = r_err;
    rsp_ark     = r_ark;
    rsp_sr      = r_sr;
    rsp_mc      = r_mc;
  end

endmodule
